// File: rtl/pc_jump_ctrl.sv
// Next-PC sequencer for the fetch stage: owns the PC, drives the PC+4 / redirect mux, and flushes wrong-path fetches.
// Optional misaligned-target trap is enabled by defining PCJ_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module pc_jump_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] jump_addr_o,
  output logic        sel_o,
  output logic        flush_o,
  output logic        fetch_valid_o,
  output logic        trap_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam bit PARAMS_OK = (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 15) &&
                             (TRAP_VEC[1:0] == 2'b00);

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [3:0]  flush_cnt, flush_cnt_next;
  logic [31:0] raw_target;
  logic [31:0] eff_target;
  logic        redirect;

  // Jump wins over branch; requests only count when the PC is on the correct path.
  assign raw_target = jump_req_i ? jump_target_i : branch_target_i;
  assign redirect   = ((state == RUN) || (state == STALL)) && (jump_req_i || branch_taken_i);

`ifdef PCJ_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |raw_target[1:0];
  assign eff_target = misaligned ? TRAP_VEC : raw_target;
`else
  assign eff_target = raw_target & ~32'h0000_0003;
`endif

  assign pc_plus4_o = pc + 32'd4;
  assign pc_o       = pc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      flush_cnt <= '0;
    end else begin
      pc        <= pc_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    flush_cnt_next = flush_cnt;
    case (state)
      BOOT: state_next = RUN;
      RUN, STALL: begin
        if (redirect) begin
          pc_next        = eff_target;
          flush_cnt_next = FLUSH_LOAD;
          state_next     = FLUSH;
        end else if (stall_i) begin
          state_next = STALL;
        end else if (state == RUN) begin
          pc_next = pc_plus4_o;
        end else begin
          // Leaving STALL costs one cycle with the PC still held.
          state_next = RUN;
        end
      end
      FLUSH: begin
        if (!stall_i) begin
          pc_next        = pc_plus4_o;
          flush_cnt_next = flush_cnt - 4'd1;
          if (flush_cnt <= 4'd1) state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    sel_o         = redirect;
    jump_addr_o   = redirect ? eff_target : 32'h0;
    flush_o       = (state == FLUSH);
    fetch_valid_o = (state == RUN) && !stall_i;
    trap_o        = 1'b0;
`ifdef PCJ_MISALIGN_TRAP_EN
    trap_o        = redirect && misaligned;
`endif
  end

  a_params_ok: assert property (@(posedge clk) PARAMS_OK);
  a_target_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    sel_o |-> (jump_addr_o[1:0] == 2'b00));

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Self-checking bench for pc_jump_ctrl: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model. Honours PCJ_MISALIGN_TRAP_EN like the design.
`timescale 1ns/1ps
module tb_pc_jump_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FC       = 2;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        jump_req_i = 1'b0;
  logic [31:0] jump_target_i = '0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] pc_o, pc_plus4_o, jump_addr_o;
  logic        sel_o, flush_o, fetch_valid_o, trap_o;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  pc_jump_ctrl #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .jump_req_i(jump_req_i), .jump_target_i(jump_target_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .jump_addr_o(jump_addr_o),
    .sel_o(sel_o), .flush_o(flush_o), .fetch_valid_o(fetch_valid_o), .trap_o(trap_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model: boot cycle pending, stalled flag, wrong-path cycles left, and the PC.
  typedef struct packed {
    logic        boot;
    logic        stalled;
    logic [7:0]  flush_left;
    logic [31:0] pc;
  } model_t;

  localparam model_t MODEL_RESET = '{boot: 1'b1, stalled: 1'b0, flush_left: 8'd0, pc: RESET_PC};

  model_t m;

  function automatic logic [31:0] landing(input logic [31:0] t);
`ifdef PCJ_MISALIGN_TRAP_EN
    return (t % 4 != 0) ? TRAP_VEC : t;
`else
    return t - (t % 4);
`endif
  endfunction

  function automatic logic on_path(input model_t s);
    return !s.boot && (s.flush_left == 0);
  endfunction

  function automatic model_t step(input model_t s, input logic st, input logic jr,
                                  input logic [31:0] jt, input logic br, input logic [31:0] bt);
    model_t n = s;
    if (s.boot) begin
      n.boot = 1'b0;
    end else if (on_path(s) && (jr || br)) begin
      n.pc         = landing(jr ? jt : bt);
      n.flush_left = 8'(FC);
      n.stalled    = 1'b0;
    end else if (s.flush_left != 0) begin
      if (!st) begin
        n.pc         = s.pc + 32'd4;
        n.flush_left = s.flush_left - 8'd1;
      end
    end else if (s.stalled) begin
      n.stalled = st;
    end else if (st) begin
      n.stalled = 1'b1;
    end else begin
      n.pc = s.pc + 32'd4;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= MODEL_RESET;
    else        m <= step(m, stall_i, jump_req_i, jump_target_i, branch_taken_i, branch_target_i);
  end

  always @(negedge clk) begin
    logic        redir;
    logic [31:0] raw;
    logic        exp_trap;
    if (rst_n && cmp_en) begin
      raw   = jump_req_i ? jump_target_i : branch_target_i;
      redir = on_path(m) && (jump_req_i || branch_taken_i);
`ifdef PCJ_MISALIGN_TRAP_EN
      exp_trap = redir && (raw % 4 != 0);
`else
      exp_trap = 1'b0;
`endif
      check("pc", pc_o, m.pc);
      check("pc_plus4", pc_plus4_o, m.pc + 32'd4);
      check("sel", 32'(sel_o), 32'(redir));
      check("jump_addr", jump_addr_o, redir ? landing(raw) : 32'h0);
      check("flush", 32'(flush_o), 32'(m.flush_left != 0));
      check("valid", 32'(fetch_valid_o), 32'(on_path(m) && !m.stalled && !stall_i));
      check("trap", 32'(trap_o), 32'(exp_trap));
    end
  end

  task automatic drive(input logic st, input logic jr, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt);
    stall_i = st; jump_req_i = jr; jump_target_i = jt;
    branch_taken_i = br; branch_target_i = bt;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc_o, RESET_PC);
    check("rst_flush", 32'(flush_o), 32'h0);
    check("rst_valid", 32'(fetch_valid_o), 32'h0);
    check("rst_jump_addr", jump_addr_o, 32'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Boot cycle then sequential fetch.
    idle(); check("t1_boot_pc", pc_o, 32'h0); check("t1_boot_valid", 32'(fetch_valid_o), 32'h0); next_cycle();
    idle(); check("t1_pc0", pc_o, 32'h0); check("t1_valid0", 32'(fetch_valid_o), 32'h1); next_cycle();
    idle(); check("t1_pc4", pc_o, 32'h4); next_cycle();
    // Jump to 0x40 from 0x8; a branch during the flush is ignored.
    drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    check("t2_pc8", pc_o, 32'h8); check("t2_sel", 32'(sel_o), 32'h1); check("t2_addr", jump_addr_o, 32'h40);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    check("t2_pc40", pc_o, 32'h40); check("t2_flush", 32'(flush_o), 32'h1); check("t3_sel_in_flush", 32'(sel_o), 32'h0);
    next_cycle();
    idle(); check("t2_pc44", pc_o, 32'h44); check("t2_flush2", 32'(flush_o), 32'h1); next_cycle();
    // Jump and branch together: jump wins.
    drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h200);
    check("t2_pc48_valid", 32'(fetch_valid_o), 32'h1); check("t3_addr", jump_addr_o, 32'h80);
    next_cycle();
    idle(); check("t3_pc80", pc_o, 32'h80); next_cycle();
    idle(); next_cycle();
    drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0); check("t3_pc88", pc_o, 32'h88); next_cycle();
    idle(); next_cycle();
    idle(); next_cycle();
    // Stall three cycles at 0x10.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); check("t4_pc10", pc_o, 32'h10); check("t4_valid", 32'(fetch_valid_o), 32'h0); next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); check("t4_hold1", pc_o, 32'h10); next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); check("t4_hold2", pc_o, 32'h10); next_cycle();
    idle(); check("t4_hold3", pc_o, 32'h10); check("t4_valid3", 32'(fetch_valid_o), 32'h0); next_cycle();
    idle(); check("t4_resume_valid", 32'(fetch_valid_o), 32'h1); next_cycle();
    // Jump accepted while stalled.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); check("t4_pc14", pc_o, 32'h14); next_cycle();
    drive(1'b1, 1'b1, 32'h60, 1'b0, 32'h0); check("t4_stall_sel", 32'(sel_o), 32'h1); next_cycle();
    idle(); check("t4_pc60", pc_o, 32'h60); next_cycle();
    idle(); next_cycle();
    // Wrap-around at the top of the address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b0, 32'h0); check("t5_pc68", pc_o, 32'h68); next_cycle();
    idle(); next_cycle();
    idle(); next_cycle();
    idle(); check("t5_pcfffc", pc_o, 32'hFFFF_FFFC); check("t5_plus4_wrap", pc_plus4_o, 32'h0); next_cycle();
    // Misaligned target.
    drive(1'b0, 1'b1, 32'h42, 1'b0, 32'h0);
    check("t5_pc_wrapped", pc_o, 32'h0);
`ifdef PCJ_MISALIGN_TRAP_EN
    check("t6_addr", jump_addr_o, 32'h100); check("t6_trap", 32'(trap_o), 32'h1);
`else
    check("t6_addr", jump_addr_o, 32'h40); check("t6_trap", 32'(trap_o), 32'h0);
`endif
    next_cycle();
    idle();
`ifdef PCJ_MISALIGN_TRAP_EN
    check("t6_pc", pc_o, 32'h100);
`else
    check("t6_pc", pc_o, 32'h40);
`endif
    // Reset asserted mid-flush takes effect immediately.
    #2 rst_n = 1'b0;
    jump_req_i = 1'b1; jump_target_i = 32'h300;
    #1;
    check("t5_rst_pc", pc_o, RESET_PC);
    check("t5_rst_flush", 32'(flush_o), 32'h0);
    check("t5_rst_sel", 32'(sel_o), 32'h0);
    next_cycle();
    jump_req_i = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] jt, bt;
      jt = $urandom;
      bt = $urandom;
      if ($urandom_range(0, 7) == 0) jt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      stall_i         = ($urandom_range(0, 99) < 20);
      jump_req_i      = ($urandom_range(0, 99) < 8);
      branch_taken_i  = ($urandom_range(0, 99) < 8);
      jump_target_i   = jt;
      branch_target_i = bt;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
      end else begin
        next_cycle();
      end
    end

    stall_i = 1'b0; jump_req_i = 1'b0; branch_taken_i = 1'b0;
    repeat (4) next_cycle();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
